mux2_stream_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 2:1 data mux between two valid/ready streaming requesters (i0, i1).
- Grants whole packets, delimited by last. An optional beat limit forces release so no requester can starve the other.
- Drives the mux select internally and exposes it as sel for debug and downstream steering.
- Sits between two producers and a single shared consumer.

---
 rtl/mux2_arb_pkg.sv | 13 +
 rtl/mux2_stream_arbiter_mux2.sv | 13 +
 rtl/mux2_stream_arbiter.sv | 130 +++++++++++++
 tb/tb_mux2_stream_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester stream arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;

endpackage

// File: rtl/mux2_stream_arbiter_mux2.sv
// Plain 2:1 mux; instantiated once per bit group of the shared stream path.
module mux2_stream_arbiter_mux2 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin packet arbiter sharing one 2:1 mux between two valid/ready streams.
//
// state    | meaning
// ST_IDLE  | no grant; arbitrate on the next edge, ready held low
// ST_GNT0  | i0 owns the mux until last or the beat limit
// ST_GNT1  | i1 owns the mux until last or the beat limit
module mux2_stream_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 16,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i0_valid,
    input  logic [DW-1:0] i0_data,
    input  logic          i0_last,
    output logic          i0_ready,
    input  logic          i1_valid,
    input  logic [DW-1:0] i1_data,
    input  logic          i1_last,
    output logic          i1_ready,
    output logic          y_valid,
    output logic [DW-1:0] y_data,
    output logic          y_last,
    input  logic          y_ready,
    output logic          sel,
    output logic          busy
);

    localparam bit            LIMITED  = (MAX_BEATS != 0);
    localparam logic [CW-1:0] LAST_CNT = LIMITED ? CW'(MAX_BEATS - 1) : '0;

    arb_state_e    state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          sel_q, sel_d;
    logic          busy_q, busy_d;

    logic          cur_valid;
    logic          xfer;
    logic          hit_limit;
    logic          release_gnt;

    mux2_stream_arbiter_mux2 #(.W(DW)) u_data_mux (
        .a (i0_data),
        .b (i1_data),
        .s (sel_q),
        .y (y_data)
    );

    mux2_stream_arbiter_mux2 #(.W(1)) u_last_mux (
        .a (i0_last),
        .b (i1_last),
        .s (sel_q),
        .y (y_last)
    );

    mux2_stream_arbiter_mux2 #(.W(1)) u_valid_mux (
        .a (i0_valid),
        .b (i1_valid),
        .s (sel_q),
        .y (cur_valid)
    );

    assign y_valid  = busy_q & cur_valid;
    assign i0_ready = (state_q == ST_GNT0) & y_ready;
    assign i1_ready = (state_q == ST_GNT1) & y_ready;
    assign sel      = sel_q;
    assign busy     = busy_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        xfer        = y_valid & y_ready;
        hit_limit   = LIMITED && (beat_cnt_q == LAST_CNT);
        release_gnt = xfer & (y_last | hit_limit);

        case (state_q)
            ST_IDLE: begin
                if (i0_valid && (!i1_valid || rr_ptr_q == SEL_I0)) begin
                    state_d = ST_GNT0;
                    sel_d   = SEL_I0;
                    busy_d  = 1'b1;
                end else if (i1_valid) begin
                    state_d = ST_GNT1;
                    sel_d   = SEL_I1;
                    busy_d  = 1'b1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                // Releasing always passes through IDLE, so the other side gets a turn.
                if (release_gnt) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = ~sel_q;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= SEL_I0;
            beat_cnt_q <= '0;
            sel_q      <= SEL_I0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Scoreboard bench for mux2_stream_arbiter, built with a beat limit of 4.
module tb_mux2_stream_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v [2];
    logic [7:0] d [2];
    logic       l [2];
    logic       yr = 1'b1;
    bit         abort = 1'b0;

    logic       i0_ready, i1_ready, y_valid, y_last, sel, busy;
    logic [7:0] y_data;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    logic [8:0] exp0 [$];
    logic [8:0] exp1 [$];
    int         log_src [$];
    int         log_cyc [$];

    mux2_stream_arbiter #(.DW(8), .MAX_BEATS(4), .CW(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0_valid (v[0]),
        .i0_data  (d[0]),
        .i0_last  (l[0]),
        .i0_ready (i0_ready),
        .i1_valid (v[1]),
        .i1_data  (d[1]),
        .i1_last  (l[1]),
        .i1_ready (i1_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .y_last   (y_last),
        .y_ready  (yr),
        .sel      (sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Scoreboard: every accepted output beat must match the next beat queued by its source.
    always @(negedge clk) begin : mon
        int         src;
        logic [8:0] e;
        if (rst_n && y_valid && yr) begin
            src = int'(sel);
            log_src.push_back(src);
            log_cyc.push_back(cyc);
            tests_run++;
            if ((src == 0 && exp0.size() == 0) || (src == 1 && exp1.size() == 0)) begin
                fails++;
                $display("FAIL scoreboard_empty: src=%0d got data=%h last=%b, required no beat", src, y_data, y_last);
            end else begin
                e = (src == 0) ? exp0.pop_front() : exp1.pop_front();
                if ({y_last, y_data} !== e) begin
                    fails++;
                    $display("FAIL scoreboard_beat: src=%0d got last/data=%b/%h, required %b/%h", src, y_last, y_data, e[8], e[7:0]);
                end
            end
            tests_run++;
            if ({i1_ready, i0_ready} !== ((src == 0) ? 2'b01 : 2'b10)) begin
                fails++;
                $display("FAIL ready_routing: src=%0d got i1/i0_ready=%b%b, required only src ready", src, i1_ready, i0_ready);
            end
        end
    end

    task automatic send_pkt(input int src, input logic [7:0] base, input int n, output int stalls);
        int waited;
        bit got;
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            if (abort) break;
            v[src] = 1'b1;
            d[src] = base + 8'(k);
            l[src] = (k == n - 1);
            if (src == 0) exp0.push_back({l[src], d[src]});
            else          exp1.push_back({l[src], d[src]});
            got = 1'b0;
            waited = 0;
            while (!got && !abort && waited < 200) begin
                @(negedge clk);
                if ((src == 0) ? i0_ready : i1_ready) got = 1'b1;
                else begin
                    stalls++;
                    waited++;
                end
            end
            if (!got && !abort) begin
                tests_run++;
                fails++;
                $display("FAIL send_timeout: src=%0d beat=%0d got no ready, required handshake", src, k);
            end
            if (!got) break;
            @(posedge clk);
            #1;
        end
        v[src] = 1'b0;
        l[src] = 1'b0;
    endtask

    task automatic check_order(input string name, input int base, input int exp_src [8], input int n);
        tests_run++;
        if (log_src.size() != base + n) begin
            fails++;
            $display("FAIL %s_count: got %0d beats, required %0d", name, log_src.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                tests_run++;
                if (log_src[base+i] !== exp_src[i]) begin
                    fails++;
                    $display("FAIL %s_order: beat %0d got src=%0d, required src=%0d", name, i, log_src[base+i], exp_src[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        v[0] = 1'b1; d[0] = 8'h10; l[0] = 1'b1;
        v[1] = 1'b0; d[1] = 8'h00; l[1] = 1'b0;
        exp0.push_back({1'b1, 8'h10});
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if ({i0_ready, i1_ready, y_valid, busy, sel} !== 5'b0) begin
                fails++;
                $display("FAIL reset_outputs: got rdy0/rdy1/yv/busy/sel=%b%b%b%b%b, required 00000",
                         i0_ready, i1_ready, y_valid, busy, sel);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || i0_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got busy=%b i0_ready=%b, required 0 0", busy, i0_ready);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || sel !== 1'b0 || i0_ready !== 1'b1 || y_data !== 8'h10) begin
            fails++;
            $display("FAIL reset_first_grant: got busy=%b sel=%b i0_ready=%b y_data=%h, required 1 0 1 10",
                     busy, sel, i0_ready, y_data);
        end
        @(posedge clk); #1;
        v[0] = 1'b0; l[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_i1();
        int base, st;
        base = log_src.size();
        send_pkt(1, 8'hA1, 3, st);
        tests_run++;
        if (st != 1) begin
            fails++;
            $display("FAIL single_latency: got %0d wait cycles, required 1", st);
        end
        tests_run++;
        if (log_src.size() != base + 3 || log_cyc[log_cyc.size()-1] - log_cyc[base] != 2) begin
            fails++;
            $display("FAIL single_consecutive: got %0d beats, required 3 beats on consecutive cycles", log_src.size() - base);
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || sel !== 1'b1 || i1_ready !== 1'b0 || i0_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: got busy=%b sel=%b rdy1=%b rdy0=%b, required 0 1 0 0", busy, sel, i1_ready, i0_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_both();
        int base, s0, s1;
        int order [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        for (int r = 0; r < 2; r++) begin
            base = log_src.size();
            fork
                send_pkt(0, 8'h20 + 8'(r * 4), 2, s0);
                send_pkt(1, 8'h30 + 8'(r * 4), 2, s1);
            join
            check_order("both", base, order, 4);
            if (log_src.size() == base + 4) begin
                tests_run++;
                if (log_cyc[base+2] - log_cyc[base+1] != 2) begin
                    fails++;
                    $display("FAIL both_idle_gap: got %0d cycles between grants, required 2", log_cyc[base+2] - log_cyc[base+1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int base, s0, w;
        base = log_src.size();
        fork
            send_pkt(0, 8'h40, 3, s0);
            begin
                w = 0;
                while (log_src.size() == base && w < 100) begin
                    @(negedge clk); #1;
                    w++;
                end
                @(posedge clk); #1;
                yr = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    tests_run++;
                    if (i0_ready !== 1'b0 || y_valid !== 1'b1 || y_data !== 8'h41 || log_src.size() != base + 1) begin
                        fails++;
                        $display("FAIL bp_hold: got rdy0=%b yv=%b y_data=%h beats=%0d, required 0 1 41 1",
                                 i0_ready, y_valid, y_data, log_src.size() - base);
                    end
                end
                @(posedge clk); #1;
                yr = 1'b1;
            end
        join
        tests_run++;
        if (s0 != 5) begin
            fails++;
            $display("FAIL bp_stalls: got %0d stall cycles, required 5", s0);
        end
        tests_run++;
        if (log_src.size() != base + 3) begin
            fails++;
            $display("FAIL bp_beats: got %0d beats, required 3", log_src.size() - base);
        end
    endtask

    task automatic test_forced_release();
        int base, s0, s1;
        int order [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
        base = log_src.size();
        fork
            send_pkt(0, 8'h50, 6, s0);
            begin
                repeat (2) @(posedge clk);
                #1;
                send_pkt(1, 8'h60, 2, s1);
            end
        join
        check_order("forced", base, order, 8);
        if (log_src.size() == base + 8) begin
            tests_run++;
            if (log_cyc[base+4] - log_cyc[base+3] != 2) begin
                fails++;
                $display("FAIL forced_gap: got %0d cycles after beat 4, required 2", log_cyc[base+4] - log_cyc[base+3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base, s0, s1, w;
        int order [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        base = log_src.size();
        fork
            send_pkt(1, 8'h70, 3, s1);
            begin
                w = 0;
                while (log_src.size() == base && w < 100) begin
                    @(negedge clk); #1;
                    w++;
                end
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                abort = 1'b1;
                #1;
                tests_run++;
                if ({i1_ready, y_valid, busy, sel} !== 4'b0) begin
                    fails++;
                    $display("FAIL reset_mid_async: got rdy1/yv/busy/sel=%b%b%b%b, required 0000",
                             i1_ready, y_valid, busy, sel);
                end
            end
        join
        exp0.delete();
        exp1.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        abort = 1'b0;
        @(posedge clk); #1;
        base = log_src.size();
        fork
            send_pkt(0, 8'h80, 1, s0);
            send_pkt(1, 8'h90, 1, s1);
        join
        check_order("reset_mid_tie", base, order, 2);
    endtask

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        d[0] = 8'h00; d[1] = 8'h00;
        l[0] = 1'b0; l[1] = 1'b0;
        test_reset();
        test_single_i1();
        test_both();
        test_backpressure();
        test_forced_release();
        test_reset_mid();
        repeat (2) @(posedge clk);
        tests_run++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            fails++;
            $display("FAIL leftover_beats: got %0d/%0d undelivered, required 0/0", exp0.size(), exp1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
